// File: rtl/change_dispenser_if.sv
// Handshake bundle between change_dispenser, its upstream vending_machine
// result (done/change) and the downstream coin hopper (valid/ready/sel).
interface change_dispenser_if;
  logic       done;
  logic [7:0] change;
  logic       coin_ready;
  logic       coin_valid;
  logic [3:0] coin_sel;

  // Environment side: presents the result to pay and accepts coins.
  modport master (
    output done,
    output change,
    output coin_ready,
    input  coin_valid,
    input  coin_sel
  );

  // Dispenser side.
  modport slave (
    input  done,
    input  change,
    input  coin_ready,
    output coin_valid,
    output coin_sel
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout over denominations 20/10/5/1 with per-denomination stock.
// One coin per valid/ready handshake; flags shortfall when stock runs out.
module change_dispenser #(
  parameter int STOCK_W = 8,
  parameter int INIT_20 = 10,
  parameter int INIT_10 = 10,
  parameter int INIT_5  = 10,
  parameter int INIT_1  = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  change_dispenser_if.slave   bus,
  input  logic                refill,
  output logic                busy,
  output logic                dispense_done,
  output logic                short_change,
  output logic [7:0]          remaining,
  output logic [3:0]          stock_empty
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

  // Index 0..3 maps to denominations 1, 5, 10, 20 (same bit order as coin_sel).
  localparam logic [STOCK_W-1:0] INIT_V [4] = '{STOCK_W'(INIT_1), STOCK_W'(INIT_5),
                                               STOCK_W'(INIT_10), STOCK_W'(INIT_20)};
  localparam logic [7:0] DENOM [4] = '{8'd1, 8'd5, 8'd10, 8'd20};

  state_t             state_q, state_d;
  logic               done_q;
  logic               arm_q, arm_d;
  logic [7:0]         remaining_q, remaining_d;
  logic               short_q, short_d;
  logic [1:0]         idx_q, idx_d;
  logic [STOCK_W-1:0] stock_q [4];
  logic [STOCK_W-1:0] stock_d [4];
  logic               done_rise;
  logic               pick_ok;
  logic [1:0]         pick_idx;

  // arm_q blocks a level-high done that survives a reset from looking like a
  // fresh rising edge: done must be seen low at least once after reset.
  assign arm_d     = arm_q | ~bus.done;
  assign done_rise = bus.done & ~done_q & arm_q;

  // Largest affordable denomination that still has stock (later index wins).
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (stock_q[i] != '0 && DENOM[i] <= remaining_q) begin
        pick_ok  = 1'b1;
        pick_idx = 2'(i);
      end
    end
  end

  // Next-state and datapath updates for the payout FSM.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    short_d     = short_q;
    idx_d       = idx_q;
    for (int i = 0; i < 4; i++) stock_d[i] = stock_q[i];
    case (state_q)
      IDLE: begin
        if (done_rise) begin
          remaining_d = bus.change;
          short_d     = 1'b0;
          state_d     = SELECT;
        end else if (refill) begin
          for (int i = 0; i < 4; i++) stock_d[i] = INIT_V[i];
        end
      end
      SELECT: begin
        if (remaining_q == 8'd0) begin
          state_d = FINISH;
        end else if (pick_ok) begin
          idx_d   = pick_idx;
          state_d = ISSUE;
        end else begin
          short_d = 1'b1;
          state_d = FINISH;
        end
      end
      ISSUE: begin
        if (bus.coin_ready) begin
          remaining_d    = remaining_q - DENOM[idx_q];
          stock_d[idx_q] = stock_q[idx_q] - STOCK_W'(1);
          state_d        = SELECT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      arm_q       <= 1'b0;
      remaining_q <= 8'd0;
      short_q     <= 1'b0;
      idx_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      done_q      <= bus.done;
      arm_q       <= arm_d;
      remaining_q <= remaining_d;
      short_q     <= short_d;
      idx_q       <= idx_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stock
      // Stock counter per denomination; reset restores the initial fill.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stock_q[gi] <= INIT_V[gi];
        else          stock_q[gi] <= stock_d[gi];
      end
      assign stock_empty[gi] = (stock_q[gi] == '0);
    end
  endgenerate

  assign bus.coin_valid = (state_q == ISSUE);
  assign bus.coin_sel   = (state_q == ISSUE) ? (4'b0001 << idx_q) : 4'b0000;
  assign busy           = (state_q != IDLE);
  assign dispense_done  = (state_q == FINISH);
  assign short_change   = short_q;
  assign remaining      = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances (default stock,
// no 20-coins, a single 1-coin) exercised one after another.
module tb_change_dispenser;

  logic clk;
  logic rst_n;
  logic refill;

  logic       busy_w   [3];
  logic       dd_w     [3];
  logic       short_w  [3];
  logic [7:0] rem_w    [3];
  logic [3:0] empty_w  [3];

  change_dispenser_if ifa ();
  change_dispenser_if ifb ();
  change_dispenser_if ifc ();

  change_dispenser u_a (
    .clk(clk), .reset_n(rst_n), .bus(ifa.slave), .refill(refill),
    .busy(busy_w[0]), .dispense_done(dd_w[0]), .short_change(short_w[0]),
    .remaining(rem_w[0]), .stock_empty(empty_w[0])
  );

  change_dispenser #(.INIT_20(0)) u_b (
    .clk(clk), .reset_n(rst_n), .bus(ifb.slave), .refill(refill),
    .busy(busy_w[1]), .dispense_done(dd_w[1]), .short_change(short_w[1]),
    .remaining(rem_w[1]), .stock_empty(empty_w[1])
  );

  change_dispenser #(.INIT_1(1)) u_c (
    .clk(clk), .reset_n(rst_n), .bus(ifc.slave), .refill(refill),
    .busy(busy_w[2]), .dispense_done(dd_w[2]), .short_change(short_w[2]),
    .remaining(rem_w[2]), .stock_empty(empty_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Snapshot of the selected instance.
  logic       s_valid, s_rdy, s_busy, s_dd, s_short;
  logic [3:0] s_sel, s_empty;
  logic [7:0] s_rem;

  // Per-transaction observations.
  logic [31:0] coin_seq;
  int          coin_n, n20, busy_n, valid_n, dd_n, done_at;
  logic [3:0]  empty_and;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int id);
    case (id)
      0: begin s_valid = ifa.coin_valid; s_sel = ifa.coin_sel; s_rdy = ifa.coin_ready; end
      1: begin s_valid = ifb.coin_valid; s_sel = ifb.coin_sel; s_rdy = ifb.coin_ready; end
      default: begin s_valid = ifc.coin_valid; s_sel = ifc.coin_sel; s_rdy = ifc.coin_ready; end
    endcase
    s_busy  = busy_w[id];
    s_dd    = dd_w[id];
    s_short = short_w[id];
    s_rem   = rem_w[id];
    s_empty = empty_w[id];
  endtask

  task automatic drive(input int id, input logic d, input logic [7:0] amt);
    case (id)
      0: begin ifa.done = d; ifa.change = amt; end
      1: begin ifb.done = d; ifb.change = amt; end
      default: begin ifc.done = d; ifc.change = amt; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise done with the given amount and watch until one cycle past the
  // dispense_done pulse (or the cycle budget runs out).
  task automatic run_txn(input int id, input logic [7:0] amt, input int max_cyc);
    coin_seq = '0; coin_n = 0; n20 = 0; busy_n = 0; valid_n = 0; dd_n = 0;
    done_at = -1; empty_and = 4'hF;
    drive(id, 1'b0, amt);
    tick();
    drive(id, 1'b1, amt);
    for (int j = 0; j < max_cyc; j++) begin
      tick();
      snap(id);
      empty_and &= s_empty;
      if (s_busy) busy_n++;
      if (s_valid) valid_n++;
      if (s_valid && s_rdy) begin
        coin_seq = (coin_seq << 4) | 32'(s_sel);
        coin_n++;
        if (s_sel == 4'b1000) n20++;
      end
      if (s_dd) begin
        dd_n++;
        if (done_at < 0) done_at = j;
      end
      if (done_at >= 0 && j >= done_at + 1) break;
    end
    drive(id, 1'b0, amt);
  endtask

  initial begin
    int stable_n;
    rst_n  = 1'b0;
    refill = 1'b0;
    ifa.done = 1'b0; ifa.change = 8'd0; ifa.coin_ready = 1'b1;
    ifb.done = 1'b0; ifb.change = 8'd0; ifb.coin_ready = 1'b1;
    ifc.done = 1'b0; ifc.change = 8'd0; ifc.coin_ready = 1'b1;

    // Reset state.
    repeat (3) tick();
    snap(0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_sel", 32'(s_sel), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_dd", 32'(s_dd), 32'd0);
    check("rst_short", 32'(s_short), 32'd0);
    check("rst_rem", 32'(s_rem), 32'd0);
    check("rst_empty_a", 32'(empty_w[0]), 32'h0);
    check("rst_empty_b", 32'(empty_w[1]), 32'h8);
    check("rst_empty_c", 32'(empty_w[2]), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic greedy payout: 17 -> 10, 5, 1, 1.
    run_txn(0, 8'd17, 20);
    check("t17_seq", coin_seq, 32'h4211);
    check("t17_n", 32'(coin_n), 32'd4);
    check("t17_done_at", 32'(done_at), 32'd9);
    check("t17_dd_n", 32'(dd_n), 32'd1);
    check("t17_short", 32'(s_short), 32'd0);
    check("t17_rem", 32'(s_rem), 32'd0);

    // Zero change.
    run_txn(0, 8'd0, 10);
    check("t0_valid_n", 32'(valid_n), 32'd0);
    check("t0_done_at", 32'(done_at), 32'd1);
    check("t0_busy_n", 32'(busy_n), 32'd2);

    // Backpressure: change 20, coin_ready low for 5 ISSUE cycles.
    stable_n = 0; coin_n = 0; done_at = -1;
    drive(0, 1'b0, 8'd20);
    tick();
    ifa.coin_ready = 1'b0;
    drive(0, 1'b1, 8'd20);
    for (int j = 0; j < 15; j++) begin
      tick();
      snap(0);
      if (j >= 1 && j <= 5 && s_valid && s_sel == 4'b1000) stable_n++;
      if (j == 5) ifa.coin_ready = 1'b1;
      if (s_valid && ifa.coin_ready) coin_n++;
      if (s_dd) begin
        done_at = j;
        break;
      end
    end
    drive(0, 1'b0, 8'd20);
    check("bp_stable", 32'(stable_n), 32'd5);
    check("bp_coins", 32'(coin_n), 32'd1);
    check("bp_done_at", 32'(done_at), 32'd7);
    check("bp_rem", 32'(s_rem), 32'd0);
    tick();

    // Reset mid-payout: change 40, reset after the first 20-coin handshake.
    drive(0, 1'b0, 8'd40);
    tick();
    drive(0, 1'b1, 8'd40);
    tick(); tick(); tick();     // SELECT, ISSUE, SELECT after first handshake
    snap(0);
    check("mid_rem", 32'(s_rem), 32'd20);
    rst_n = 1'b0;
    #1;
    snap(0);
    check("mid_rst_busy", 32'(s_busy), 32'd0);
    check("mid_rst_valid", 32'(s_valid), 32'd0);
    check("mid_rst_sel", 32'(s_sel), 32'd0);
    check("mid_rst_rem", 32'(s_rem), 32'd0);
    check("mid_rst_dd", 32'(s_dd), 32'd0);
    tick();
    rst_n = 1'b1;             // done still held high
    busy_n = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (busy_w[0]) busy_n++;
    end
    check("held_done_idle", 32'(busy_n), 32'd0);
    // 200 is exactly ten 20-coins only if the 20 stock is back to 10.
    run_txn(0, 8'd200, 40);
    check("restore_n20", 32'(n20), 32'd10);
    check("restore_done_at", 32'(done_at), 32'd21);
    check("restore_rem", 32'(s_rem), 32'd0);
    check("restore_empty20", 32'(s_empty[3]), 32'd1);

    // Empty-denomination fallback on the instance with no 20-coins.
    run_txn(1, 8'd25, 20);
    check("e20_seq", coin_seq, 32'h442);
    check("e20_done_at", 32'(done_at), 32'd7);
    check("e20_empty3", 32'(empty_and[3]), 32'd1);
    check("e20_rem", 32'(s_rem), 32'd0);
    check("e20_short", 32'(s_short), 32'd0);

    // Shortfall on the instance with a single 1-coin.
    run_txn(2, 8'd3, 20);
    check("sf_seq", coin_seq, 32'h1);
    check("sf_done_at", 32'(done_at), 32'd3);
    check("sf_dd_n", 32'(dd_n), 32'd1);
    check("sf_short", 32'(s_short), 32'd1);
    check("sf_rem", 32'(s_rem), 32'd2);
    check("sf_empty", 32'(s_empty), 32'h1);
    refill = 1'b1;
    tick();
    refill = 1'b0;
    snap(2);
    check("sf_refill_empty", 32'(s_empty), 32'h0);
    check("sf_short_held", 32'(s_short), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
